// File: rtl/bus_pkg.sv
`default_nettype none
// ============================================================================
// Module      : bus_pkg
// Description : Shared types and constants for the bank-select bus decoder.
// Revision    : 1.0 - initial release
// ============================================================================
package bus_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACTIVE = 2'd1,
        ST_RESP   = 2'd2
    } state_t;

    localparam int unsigned C_ADDR_W = 32;
    localparam int unsigned C_DATA_W = 32;
    localparam int unsigned C_SEL_W  = C_DATA_W / 8;

    localparam logic [7:0] C_BANK_RAM   = 8'h00;
    localparam logic [7:0] C_BANK_LED   = 8'h01;
    localparam logic [7:0] C_BANK_VIDEO = 8'h02;
    localparam logic [7:0] C_BANK_UART  = 8'h03;

    localparam logic [31:0] C_DEFAULT_SLV_BANK =
        {C_BANK_UART, C_BANK_VIDEO, C_BANK_LED, C_BANK_RAM};

    // Slave index width, never below one bit so a single-slave build still has a port.
    function automatic int unsigned idx_width(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/bus_addr_match.sv
`default_nettype none
// ============================================================================
// Module      : bus_addr_match
// Description : Combinational bank-ID comparator; lowest matching slave wins.
// Revision    : 1.0 - initial release
// ============================================================================
module bus_addr_match
    import bus_pkg::*;
#(
    parameter int unsigned            NSLV     = 4,
    parameter int unsigned            BANK_W   = 8,
    parameter logic [NSLV*BANK_W-1:0] SLV_BANK = C_DEFAULT_SLV_BANK,
    parameter int unsigned            IDX_W    = idx_width(NSLV)
) (
    input  logic [BANK_W-1:0] i_bank,
    output logic              o_hit,
    output logic [IDX_W-1:0]  o_idx
);

    // Scan from the top so the lowest matching index overwrites any higher one.
    always_comb begin
        o_hit = 1'b0;
        o_idx = '0;
        for (int k = NSLV - 1; k >= 0; k--) begin
            if (i_bank == SLV_BANK[k*BANK_W +: BANK_W]) begin
                o_hit = 1'b1;
                o_idx = IDX_W'(k);
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/bus_decoder.sv
`default_nettype none
// ============================================================================
// Module      : bus_decoder
// Description : Single-master to NSLV-slave decoder with timeout and error log.
// Revision    : 1.0 - initial release
// ============================================================================
module bus_decoder
    import bus_pkg::*;
#(
    parameter int unsigned            NSLV     = 4,
    parameter int unsigned            BANK_LSB = 24,
    parameter int unsigned            BANK_W   = 8,
    parameter logic [NSLV*BANK_W-1:0] SLV_BANK = C_DEFAULT_SLV_BANK,
    parameter int unsigned            TIMEOUT  = 255
) (
    input  logic                     clk,
    input  logic                     rst_ni,
    input  logic                     m_stb_i,
    input  logic                     m_we_i,
    input  logic [C_ADDR_W-1:0]      m_adr_i,
    input  logic [C_SEL_W-1:0]       m_sel_i,
    input  logic [C_DATA_W-1:0]      m_dat_i,
    output logic [C_DATA_W-1:0]      m_dat_o,
    output logic                     m_ack_o,
    output logic                     m_err_o,
    output logic [NSLV-1:0]          s_stb_o,
    output logic                     s_we_o,
    output logic [C_ADDR_W-1:0]      s_adr_o,
    output logic [C_SEL_W-1:0]       s_sel_o,
    output logic [C_DATA_W-1:0]      s_dat_o,
    input  logic [NSLV*C_DATA_W-1:0] s_dat_i,
    input  logic [NSLV-1:0]          s_ack_i,
    output logic [15:0]              err_cnt_o,
    output logic [C_ADDR_W-1:0]      err_adr_o
);

    localparam int unsigned IDX_W = idx_width(NSLV);

    state_t                r_state, w_next;
    logic                  r_we, r_ack, r_err;
    logic [C_ADDR_W-1:0]   r_adr, r_err_adr;
    logic [C_SEL_W-1:0]    r_sel;
    logic [C_DATA_W-1:0]   r_dat, r_rdat;
    logic [IDX_W-1:0]      r_idx, w_idx;
    logic [15:0]           r_cnt, r_err_cnt;
    logic                  w_hit, w_sel_ack, w_timeout;
    logic                  w_start, w_unmapped, w_done_ack, w_done_to;
    logic [NSLV-1:0]       w_stb;
    logic [C_DATA_W-1:0]   w_sel_dat, w_rd_masked;

    bus_addr_match #(
        .NSLV     (NSLV),
        .BANK_W   (BANK_W),
        .SLV_BANK (SLV_BANK),
        .IDX_W    (IDX_W)
    ) u_match (
        .i_bank (m_adr_i[BANK_LSB +: BANK_W]),
        .o_hit  (w_hit),
        .o_idx  (w_idx)
    );

    // Only the addressed slave's ack and data are visible; stray acks fall away here.
    always_comb begin
        w_stb     = '0;
        w_sel_ack = 1'b0;
        w_sel_dat = '0;
        for (int k = 0; k < NSLV; k++) begin
            if (r_idx == IDX_W'(k)) begin
                w_stb[k]  = (r_state == ST_ACTIVE);
                w_sel_ack = s_ack_i[k];
                w_sel_dat = s_dat_i[k*C_DATA_W +: C_DATA_W];
            end
        end
    end

    always_comb begin
        w_rd_masked = '0;
        for (int b = 0; b < C_SEL_W; b++) begin
            if (r_sel[b]) w_rd_masked[b*8 +: 8] = w_sel_dat[b*8 +: 8];
        end
    end

    assign w_timeout = (r_cnt == 16'(TIMEOUT - 1));

    always_comb begin
        w_next     = r_state;
        w_start    = 1'b0;
        w_unmapped = 1'b0;
        w_done_ack = 1'b0;
        w_done_to  = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (m_stb_i) begin
                    if (w_hit) begin
                        w_next  = ST_ACTIVE;
                        w_start = 1'b1;
                    end else begin
                        w_next     = ST_RESP;
                        w_unmapped = 1'b1;
                    end
                end
            end
            ST_ACTIVE: begin
                if (!m_stb_i) begin
                    w_next = ST_IDLE;
                end else if (w_sel_ack) begin
                    w_next     = ST_RESP;
                    w_done_ack = 1'b1;
                end else if (w_timeout) begin
                    w_next    = ST_RESP;
                    w_done_to = 1'b1;
                end
            end
            ST_RESP: w_next = ST_IDLE;
            default: w_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_ni) begin
        if (!rst_ni) begin
            r_state <= ST_IDLE;
            r_ack   <= 1'b0;
            r_err   <= 1'b0;
            r_cnt   <= '0;
        end else begin
            r_state <= w_next;
            r_ack   <= w_done_ack;
            r_err   <= w_unmapped | w_done_to;
            if (w_start)
                r_cnt <= '0;
            else if (r_state == ST_ACTIVE && m_stb_i && !w_sel_ack && !w_timeout)
                r_cnt <= r_cnt + 16'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_ni) begin
        if (!rst_ni) begin
            r_we  <= 1'b0;
            r_adr <= '0;
            r_sel <= '0;
            r_dat <= '0;
            r_idx <= '0;
        end else if (r_state == ST_IDLE && m_stb_i) begin
            r_we  <= m_we_i;
            r_adr <= m_adr_i;
            r_sel <= m_sel_i;
            r_dat <= m_dat_i;
            r_idx <= w_idx;
        end
    end

    always_ff @(posedge clk or negedge rst_ni) begin
        if (!rst_ni) begin
            r_rdat    <= '0;
            r_err_cnt <= '0;
            r_err_adr <= '0;
        end else begin
            if (w_done_ack && !r_we) r_rdat <= w_rd_masked;
            // Unmapped accesses are logged in the same edge that latches the address.
            if (w_unmapped || w_done_to) begin
                if (r_err_cnt != 16'hFFFF) r_err_cnt <= r_err_cnt + 16'd1;
                r_err_adr <= w_unmapped ? m_adr_i : r_adr;
            end
        end
    end

    assign m_dat_o   = r_rdat;
    assign m_ack_o   = r_ack;
    assign m_err_o   = r_err;
    assign s_stb_o   = w_stb;
    assign s_we_o    = r_we;
    assign s_adr_o   = r_adr;
    assign s_sel_o   = r_sel;
    assign s_dat_o   = r_dat;
    assign err_cnt_o = r_err_cnt;
    assign err_adr_o = r_err_adr;

endmodule
`default_nettype wire

// File: tb/tb_bus_decoder.sv
`default_nettype none
// ============================================================================
// Module      : tb_bus_decoder
// Description : Randomised self-checking bench for bus_decoder with a
//               transaction-level reference model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_bus_decoder;

    localparam int NSLV = 4;
    localparam int TO   = 8;

    logic                 clk = 1'b0;
    logic                 rst_ni;
    logic                 m_stb_i, m_we_i;
    logic [31:0]          m_adr_i, m_dat_i;
    logic [3:0]           m_sel_i;
    logic [31:0]          m_dat_o;
    logic                 m_ack_o, m_err_o;
    logic [NSLV-1:0]      s_stb_o;
    logic                 s_we_o;
    logic [31:0]          s_adr_o, s_dat_o;
    logic [3:0]           s_sel_o;
    logic [NSLV*32-1:0]   s_dat_i;
    logic [NSLV-1:0]      s_ack_i;
    logic [15:0]          err_cnt_o;
    logic [31:0]          err_adr_o;

    int          n_checks = 0;
    int          n_errors = 0;
    logic [31:0] exp_dat    = '0;
    logic [15:0] exp_errcnt = '0;
    logic [31:0] exp_erradr = '0;
    logic [7:0]  bank_id [NSLV] = '{8'h00, 8'h01, 8'h02, 8'h03};

    bus_decoder #(.TIMEOUT(TO)) dut (
        .clk       (clk),
        .rst_ni    (rst_ni),
        .m_stb_i   (m_stb_i),
        .m_we_i    (m_we_i),
        .m_adr_i   (m_adr_i),
        .m_sel_i   (m_sel_i),
        .m_dat_i   (m_dat_i),
        .m_dat_o   (m_dat_o),
        .m_ack_o   (m_ack_o),
        .m_err_o   (m_err_o),
        .s_stb_o   (s_stb_o),
        .s_we_o    (s_we_o),
        .s_adr_o   (s_adr_o),
        .s_sel_o   (s_sel_o),
        .s_dat_o   (s_dat_o),
        .s_dat_i   (s_dat_i),
        .s_ack_i   (s_ack_i),
        .err_cnt_o (err_cnt_o),
        .err_adr_o (err_adr_o)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] byte_mask(input logic [31:0] d, input logic [3:0] sel);
        logic [31:0] r = '0;
        for (int b = 0; b < 4; b++) if (sel[b]) r[b*8 +: 8] = d[b*8 +: 8];
        return r;
    endfunction

    task automatic check_idle_outputs(input string name);
        n_checks++;
        if ({m_ack_o, m_err_o, s_stb_o} !== '0 || m_dat_o !== exp_dat ||
            err_cnt_o !== exp_errcnt || err_adr_o !== exp_erradr) begin
            n_errors++;
            $display("FAIL %s: ack=%b err=%b stb=%b dat=%h cnt=%0d eadr=%h expected ack=0 err=0 stb=0 dat=%h cnt=%0d eadr=%h",
                     name, m_ack_o, m_err_o, s_stb_o, m_dat_o, err_cnt_o, err_adr_o,
                     exp_dat, exp_errcnt, exp_erradr);
        end
    endtask

    // One complete access. Outcome and timing come from the decode table and
    // the slave's wait count; the task starts and ends on a falling edge.
    task automatic run_txn(input logic we, input logic [31:0] adr, input logic [3:0] sel,
                           input logic [31:0] wdat, input int delay, input logic [31:0] rdat,
                           input bit stray, input string name);
        int  slv = -1;
        int  exp_cyc, exp_stb, stb_cnt = 0, resp_cyc = 0;
        bit  exp_ack, got_ack = 0, got_err = 0, stb_bad = 0, lat_bad = 0;
        for (int k = 0; k < NSLV; k++)
            if (slv < 0 && adr[31:24] == bank_id[k]) slv = k;
        if (slv < 0) begin
            exp_ack = 0; exp_cyc = 1; exp_stb = 0;
        end else if (delay < TO) begin
            exp_ack = 1; exp_cyc = delay + 2; exp_stb = delay + 1;
        end else begin
            exp_ack = 0; exp_cyc = TO + 1; exp_stb = TO;
        end

        m_stb_i = 1'b1; m_we_i = we; m_adr_i = adr; m_sel_i = sel; m_dat_i = wdat;
        s_ack_i = '0;
        for (int cyc = 1; cyc <= TO + 6; cyc++) begin
            @(negedge clk);
            if (s_stb_o != '0) begin
                stb_cnt++;
                if (slv < 0 || s_stb_o != (NSLV'(1) << slv)) stb_bad = 1;
                if (s_we_o !== we || s_adr_o !== adr || s_sel_o !== sel || s_dat_o !== wdat)
                    lat_bad = 1;
            end
            if (m_ack_o || m_err_o) begin
                resp_cyc = cyc; got_ack = m_ack_o; got_err = m_err_o;
                break;
            end
            s_ack_i = stray ? NSLV'($urandom) : '0;
            for (int k = 0; k < NSLV; k++) s_dat_i[k*32 +: 32] = $urandom;
            if (slv >= 0) begin
                s_ack_i[slv] = 1'b0;
                s_dat_i[slv*32 +: 32] = rdat;
                if (s_stb_o[slv] && stb_cnt == delay + 1) s_ack_i[slv] = 1'b1;
            end
        end
        m_stb_i = 1'b0;
        s_ack_i = '0;

        n_checks++;
        if (resp_cyc != exp_cyc) begin
            n_errors++;
            $display("FAIL %s latency: response at cycle %0d expected cycle %0d", name, resp_cyc, exp_cyc);
        end
        n_checks++;
        if (got_ack != exp_ack || got_err != !exp_ack) begin
            n_errors++;
            $display("FAIL %s resp_kind: ack=%b err=%b expected ack=%b err=%b",
                     name, got_ack, got_err, exp_ack, !exp_ack);
        end
        n_checks++;
        if (stb_cnt != exp_stb || stb_bad || lat_bad) begin
            n_errors++;
            $display("FAIL %s slave_strobe: %0d cycles (wrong_bits=%b wrong_fields=%b) expected %0d cycles to slave %0d",
                     name, stb_cnt, stb_bad, lat_bad, exp_stb, slv);
        end

        if (exp_ack && !we) exp_dat = byte_mask(rdat, sel);
        if (!exp_ack) begin
            if (exp_errcnt != 16'hFFFF) exp_errcnt++;
            exp_erradr = adr;
        end
        @(negedge clk);
        check_idle_outputs({name, " after_resp"});
    endtask

    task automatic test_reset();
        rst_ni = 1'b0; m_stb_i = 0; m_we_i = 0; m_adr_i = '0; m_sel_i = '0; m_dat_i = '0;
        s_ack_i = '0; s_dat_i = '0;
        repeat (3) @(negedge clk);
        n_checks++;
        if ({s_we_o, s_adr_o, s_sel_o, s_dat_o} !== '0) begin
            n_errors++;
            $display("FAIL reset_latches: we=%b adr=%h sel=%h dat=%h expected all 0",
                     s_we_o, s_adr_o, s_sel_o, s_dat_o);
        end
        check_idle_outputs("reset_state");
        rst_ni = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_directed();
        run_txn(1'b0, 32'h0000_0010, 4'hF, 32'h0, 0, 32'hDEADBEEF, 0, "read_slave0");
        run_txn(1'b0, 32'h0200_0000, 4'b0011, 32'h0, 4, 32'h12345678, 1, "read_masked");
        run_txn(1'b1, 32'h0700_0000, 4'hF, 32'hCAFEF00D, 0, 32'h0, 0, "unmapped_write");
    endtask

    task automatic test_timeout();
        run_txn(1'b0, 32'h0300_0100, 4'hF, 32'h0, 1000, 32'h11111111, 0, "timeout");
        run_txn(1'b0, 32'h0300_0104, 4'hC, 32'h0, 1, 32'hA5A5C3C3, 0, "after_timeout");
        run_txn(1'b0, 32'h0100_0008, 4'h5, 32'h0, TO - 1, 32'h89ABCDEF, 1, "ack_at_timeout");
    endtask

    task automatic test_abort();
        bit bad = 0;
        m_stb_i = 1; m_we_i = 0; m_adr_i = 32'h0300_0040; m_sel_i = 4'hF; m_dat_i = '0;
        repeat (3) @(negedge clk);
        m_stb_i = 0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            if (s_stb_o != '0 || m_ack_o || m_err_o) bad = 1;
        end
        n_checks++;
        if (bad) begin
            n_errors++;
            $display("FAIL abort: strobe or response seen after master abort, expected none");
        end
        check_idle_outputs("abort_counters");
    endtask

    task automatic test_reset_mid_active();
        bit bad = 0;
        m_stb_i = 1; m_we_i = 1; m_adr_i = 32'h0100_0020; m_sel_i = 4'hF; m_dat_i = 32'h5555AAAA;
        repeat (3) @(negedge clk);
        n_checks++;
        if (s_stb_o !== 4'b0010) begin
            n_errors++;
            $display("FAIL pre_reset_strobe: stb=%b expected 0010", s_stb_o);
        end
        rst_ni = 1'b0;
        m_stb_i = 0;
        #1;
        exp_dat = '0; exp_errcnt = '0; exp_erradr = '0;
        check_idle_outputs("async_reset");
        @(negedge clk);
        rst_ni = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            if (s_stb_o != '0 || m_ack_o || m_err_o) bad = 1;
        end
        n_checks++;
        if (bad) begin
            n_errors++;
            $display("FAIL post_reset_quiet: strobe or response after reset release, expected none");
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 30; i++) begin
            logic [31:0] adr = $urandom;
            int          delay;
            if ($urandom_range(0, 4) != 0) adr[31:24] = 8'($urandom_range(0, NSLV - 1));
            delay = ($urandom_range(0, 5) == 0) ? TO + 3 : int'($urandom_range(0, TO - 1));
            run_txn(1'($urandom), adr, 4'($urandom), $urandom, delay, $urandom,
                    1'($urandom), $sformatf("random%0d", i));
        end
    endtask

    initial begin
        test_reset();
        test_directed();
        test_timeout();
        test_abort();
        test_random();
        test_reset_mid_active();
        test_random();
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/bus_decoder.md
BUS_DECODER -- requirements
Module: bus_decoder

Interface
REQ-001 SHALL have parameter NSLV, default 4, number of slave ports (1..16).
REQ-002 SHALL have parameter BANK_LSB, default 24, LSB of the bank-select field in the address.
REQ-003 SHALL have parameter BANK_W, default 8, width of the bank-select field.
REQ-004 SHALL have parameter SLV_BANK, default {8'h03,8'h02,8'h01,8'h00}, flattened NSLV*BANK_W bank IDs, slot k = slave k.
REQ-005 SHALL have parameter TIMEOUT, default 255, maximum ACTIVE cycles before bus error (1..65535).
REQ-006 SHALL have port clk, input, 1, sole clock, all state updates on its rising edge.
REQ-007 SHALL have port rst_ni, input, 1, asynchronous active-low reset.
REQ-008 SHALL have ports m_stb_i 1 / m_we_i 1 / m_adr_i 32 / m_sel_i 4 / m_dat_i 32, inputs, master request.
REQ-009 SHALL have ports m_dat_o 32 / m_ack_o 1 / m_err_o 1, outputs, master response.
REQ-010 SHALL have ports s_stb_o NSLV / s_we_o 1 / s_adr_o 32 / s_sel_o 4 / s_dat_o 32, outputs, slave request, one strobe bit per slave.
REQ-011 SHALL have ports s_dat_i NSLV*32 / s_ack_i NSLV, inputs, slave responses, slice k = slave k.
REQ-012 SHALL have ports err_cnt_o 16 / err_adr_o 32, outputs, error count and address of the last errored access.

Function
REQ-013 SHALL implement FSM states IDLE, ACTIVE, RESP.
REQ-014 IDLE with m_stb_i=1: latch we/adr/sel/dat; decode m_adr_i[BANK_LSB+:BANK_W] against SLV_BANK; lowest matching index wins.
REQ-015 IDLE, match at index k: go ACTIVE; from the next cycle assert s_stb_o[k] only; drive s_we_o/s_adr_o/s_sel_o/s_dat_o from the latches.
REQ-016 IDLE, no match: go RESP with m_err_o=1; no s_stb_o is asserted.
REQ-017 ACTIVE with s_ack_i[k]=1: register s_dat_i slice k into m_dat_o, zeroing bytes whose sel bit is 0 on reads; deassert s_stb_o; go RESP with m_ack_o=1.
REQ-018 Acks from slaves other than k SHALL be ignored.
REQ-019 ACTIVE timeout counter: clears on ACTIVE entry, increments each ACTIVE cycle without ack; on reaching TIMEOUT, drop s_stb_o and go RESP with m_err_o=1.
REQ-020 Ack and timeout in the same cycle: ack wins.
REQ-021 ACTIVE with m_stb_i=0 (master abort): drop s_stb_o next cycle, return to IDLE, no ack/err, counters unchanged.
REQ-022 RESP SHALL last exactly one cycle with m_ack_o or m_err_o high (never both), then return to IDLE; m_stb_i is ignored in RESP.
REQ-023 Latency: slave ack on the first ACTIVE cycle gives m_ack_o two cycles after m_stb_i is sampled; an unmapped address gives m_err_o one cycle after.
REQ-024 m_dat_o SHALL hold its value outside RESP; write cycles leave m_dat_o unchanged.
REQ-025 Each m_err_o SHALL increment err_cnt_o, saturating at 16'hFFFF, and load err_adr_o with the latched address.

Reset
REQ-026 rst_ni=0 SHALL asynchronously force IDLE, s_stb_o=0, m_ack_o=0, m_err_o=0, m_dat_o=0, err_cnt_o=0, err_adr_o=0, timeout counter=0, latches=0.
REQ-027 Reset during ACTIVE SHALL drop s_stb_o immediately, with no response issued after release.

Structure
REQ-028 A shared package (bus_pkg) SHALL hold the FSM state enum, the bus data/address width constants and the default bank IDs (RAM 8'h00, LED 8'h01, VIDEO 8'h02, UART 8'h03).
REQ-029 Decode SHALL be a sub-module bus_addr_match: combinational, NSLV-parameterised, outputs a hit flag and the lowest index.

Verification
REQ-030 Read adr 32'h0000_0010, sel 4'hF, slave 0 acks on the first ACTIVE cycle with 32'hDEADBEEF -> m_ack_o two cycles after strobe, m_dat_o=32'hDEADBEEF, s_stb_o=4'b0001.
REQ-031 Read adr 32'h0200_0000, sel 4'b0011, slave 2 returns 32'h12345678 after 5 cycles -> m_dat_o=32'h00005678, single-cycle ack.
REQ-032 Write adr 32'h0700_0000 (unmapped) -> m_err_o one cycle after strobe, s_stb_o never set, err_cnt_o=1, err_adr_o=32'h0700_0000.
REQ-033 TIMEOUT=8, slave 3 never acks -> s_stb_o[3] high for 8 cycles, then m_err_o, err_cnt_o increments; a second access immediately afterwards succeeds.
REQ-034 Slave 1 ack coincides with the timeout cycle -> m_ack_o only; rst_ni pulsed mid-ACTIVE -> all outputs 0 with no response after release.
